// File: rtl/sdbp_pkg.sv
// Shared types and constants for the SDBP LED backlight transmitter.
// Holds the FSM state encoding, default frame constants and the CRC step.
package sdbp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    CRC,
    GAP
  } state_t;

  localparam int          NUM_ZONES_D = 360;
  localparam logic [15:0] HDR_CMD_D   = 16'hA55A;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;

  // One CRC-16-CCITT step, MSB-first, no reflection.
  function automatic logic [15:0] crc16_bit(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdbp_pingpong_ram.sv
// Two-bank zone buffer: one write port into the write bank and one
// registered read port into the bank chosen by i_rd_bank.
module sdbp_pingpong_ram
  import sdbp_pkg::*;
#(
  parameter int NUM_ZONES = NUM_ZONES_D
) (
  input  logic        clk,
  input  logic        i_wr_bank,
  input  logic        i_wr_en,
  input  logic [9:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_rd_bank,
  input  logic [9:0]  i_rd_addr,
  output logic [15:0] o_rd_data
);

  localparam int AW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

  logic [15:0] r_mem0 [NUM_ZONES];
  logic [15:0] r_mem1 [NUM_ZONES];
  logic [15:0] r_rd_data;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW-1:0] w_wa;
  logic [AW-1:0] w_ra;

  assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < NUM_ZONES);
  assign w_rd_ok = 32'(i_rd_addr) < NUM_ZONES;
  assign w_wa    = i_wr_addr[AW-1:0];
  assign w_ra    = i_rd_addr[AW-1:0];

  // Store in-range writes into the selected write bank.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      if (i_wr_bank) r_mem1[w_wa] <= i_wr_data;
      else           r_mem0[w_wa] <= i_wr_data;
    end
  end

  // Registered read; out-of-range addresses return zero.
  always_ff @(posedge clk) begin
    if (!w_rd_ok)       r_rd_data <= 16'h0000;
    else if (i_rd_bank) r_rd_data <= r_mem1[w_ra];
    else                r_rd_data <= r_mem0[w_ra];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdbp_led_tx.sv
// Frame buffer + SPI mode-0 serialiser for the LED backlight driver.
// Optional trailing CRC-16-CCITT word when SDBP_CRC_EN is defined.
module sdbp_led_tx
  import sdbp_pkg::*;
#(
  parameter int          NUM_ZONES = NUM_ZONES_D,
  parameter int          CLK_DIV   = 2,
  parameter logic [15:0] HDR_CMD   = HDR_CMD_D,
  parameter int          CS_GAP    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdbp_flag,
  input  logic [15:0] wt_dina,
  input  logic [9:0]  wt_addr,
  input  logic        wt_we,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  state_t r_state;
  state_t w_next;

  logic          r_flag_q;
  logic          r_wr_bank;
  logic [DW-1:0] r_div;
  logic          r_sclk;
  logic [3:0]    r_bit;
  logic [9:0]    r_word;
  logic [15:0]   r_shift;
  logic [GW-1:0] r_gap;
  logic          r_overrun;

  logic          w_edge;
  logic          w_tick;
  logic          w_rise;
  logic          w_fall;
  logic          w_word_end;
  logic          w_last;
  logic          w_gap_end;
  logic [15:0]   w_rd_data;
  logic [15:0]   w_tail;

  assign w_edge     = sdbp_flag & ~r_flag_q;
  assign w_tick     = (r_div == DW'(CLK_DIV - 1));
  assign w_rise     = w_tick & ~r_sclk;
  assign w_fall     = w_tick & r_sclk;
  assign w_word_end = w_fall & (r_bit == 4'd15);
  assign w_last     = (r_word == 10'(NUM_ZONES));
  assign w_gap_end  = (r_gap == GW'(CS_GAP - 1));

  // Read port follows the word counter: while word w is on the wire,
  // RAM address w (the next zone) is already sitting in the read register.
  sdbp_pingpong_ram #(
    .NUM_ZONES (NUM_ZONES)
  ) u_ram (
    .clk       (clk),
    .i_wr_bank (r_wr_bank),
    .i_wr_en   (wt_we),
    .i_wr_addr (wt_addr),
    .i_wr_data (wt_dina),
    .i_rd_bank (~r_wr_bank),
    .i_rd_addr (r_word),
    .o_rd_data (w_rd_data)
  );

`ifdef SDBP_CRC_EN
  logic [15:0] r_crc;

  // Accumulate the CRC over each bit as the receiver samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (r_state == START) begin
      r_crc <= CRC_INIT;
    end else if (r_state == SHIFT && w_rise) begin
      r_crc <= crc16_bit(r_crc, r_shift[15]);
    end
  end

  assign w_tail = r_crc;
`else
  assign w_tail = 16'h0000;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_edge) w_next = START;
      START: if (w_tick) w_next = SHIFT;
      SHIFT: begin
        if (w_word_end && w_last) begin
`ifdef SDBP_CRC_EN
          w_next = CRC;
`else
          w_next = GAP;
`endif
        end
      end
      CRC:   if (w_word_end) w_next = GAP;
      GAP:   if (w_gap_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (r_state)
      IDLE: busy = 1'b0;
      START, SHIFT, CRC: begin
        spi_cs_n = 1'b0;
        spi_mosi = r_shift[15];
      end
      GAP: frame_done = w_gap_end;
      default: busy = 1'b0;
    endcase
  end

  assign spi_sclk = r_sclk;
  assign overrun  = r_overrun;

  // Flag edge, bank swap, divider, shifter and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_q  <= 1'b0;
      r_wr_bank <= 1'b0;
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_bit     <= 4'd0;
      r_word    <= 10'd0;
      r_shift   <= 16'h0000;
      r_gap     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_flag_q <= sdbp_flag;
      if (w_edge && busy) r_overrun <= 1'b1;
      unique case (r_state)
        IDLE: begin
          r_div  <= '0;
          r_sclk <= 1'b0;
          r_bit  <= 4'd0;
          r_word <= 10'd0;
          r_gap  <= '0;
          if (w_edge) begin
            r_wr_bank <= ~r_wr_bank;
            r_shift   <= HDR_CMD;
          end
        end
        START: begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
        end
        SHIFT, CRC: begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
          if (w_tick) r_sclk <= ~r_sclk;
          if (w_fall) begin
            r_bit <= r_bit + 4'd1;
            if (!w_word_end) begin
              r_shift <= {r_shift[14:0], 1'b0};
            end else if (r_state == SHIFT && !w_last) begin
              r_shift <= w_rd_data;
              r_word  <= r_word + 10'd1;
            end else if (r_state == SHIFT) begin
              r_shift <= w_tail;
            end else begin
              r_shift <= 16'h0000;
            end
          end
        end
        GAP: begin
          r_sclk <= 1'b0;
          r_gap  <= r_gap + 1'b1;
        end
        default: r_div <= '0;
      endcase
    end
  end

endmodule

// File: doc/sdbp_led_tx.md
Name: sdbp_led_tx

Overview:
- Downstream consumer of the zone-gray producer's `sdbpflag` / `wtdina` / `wtaddr` stream.
- Captures one frame of NUM_ZONES 16-bit zone brightness values into a ping-pong buffer.
- On each frame flag, serialises the completed frame to the LED backlight driver over an SPI mode-0 link: a header word, then all zone words, MSB first.
- Single clock domain (`clk`, same as the producer's read side).

Parameters:
- NUM_ZONES, 360, number of zone words per frame (must be ≤ 1024).
- CLK_DIV, 2, `clk` cycles per SCLK half-period (≥ 1); SCLK = clk/(2*CLK_DIV).
- HDR_CMD, 16'hA55A, header command word sent before zone data.
- CS_GAP, 8, `clk` cycles `spi_cs_n` is held high after a frame before returning to IDLE.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sdbp_flag  input  1  frame-ready level from the producer; only its rising edge is used.
- wt_dina  input  16  zone gray value.
- wt_addr  input  10  zone index for `wt_dina`.
- wt_we  input  1  write strobe; `wt_dina` is stored at `wt_addr` when high.
- spi_sclk  output  1  serial clock, idles low.
- spi_mosi  output  1  serial data.
- spi_cs_n  output  1  chip select, active low.
- busy  output  1  high from transmission start through the end of the CS gap.
- frame_done  output  1  one-cycle pulse when the CS gap ends.
- overrun  output  1  sticky; set when a flag edge arrives while `busy`; cleared only by reset.

Behaviour:
- Reset values: `spi_sclk`=0, `spi_mosi`=0, `spi_cs_n`=1, `busy`=0, `frame_done`=0, `overrun`=0.
- Reset state: FSM in IDLE, write bank = 0, all counters 0. Buffer RAM contents are undefined after reset.
- Reset asserted mid-frame: all outputs return to reset values immediately; no partial word completes.
- Buffer:
  - Two banks of NUM_ZONES x 16.
  - A write with `wt_we`=1 and `wt_addr` < NUM_ZONES stores into the write bank. Writes with `wt_addr` ≥ NUM_ZONES are dropped.
  - Writes are accepted in every state, including during transmission.
  - RAM read is synchronous with 1-cycle latency. The next word is prefetched during the current word so there is no bubble between words.
- Flag detection:
  - `sdbp_flag` is registered once; edge = current & ~previous.
  - Edge in IDLE: swap banks (the old write bank becomes the read bank) and go to START on the next cycle.
  - Edge while `busy`: ignored, and `overrun` is set.
- FSM:
  - IDLE: `cs_n`=1, `sclk`=0. Leave on a flag edge.
  - START: `cs_n`=0; load the shift register with HDR_CMD; `spi_mosi` presents the MSB; wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT:
    - Divider counts CLK_DIV cycles per half-period. `sclk` rises and then falls.
    - On each falling edge, shift left and drive the next bit; the receiver samples on the rising edge.
    - After bit 0 of a word's falling edge, load the next word: word index 0 is the header, 1..NUM_ZONES are the zones read from RAM addresses 0..NUM_ZONES-1.
    - After the last word's final falling edge, go to GAP.
  - GAP: `cs_n`=1, `sclk`=0, `mosi`=0; count CS_GAP cycles, pulse `frame_done`, return to IDLE.
- Timing:
  - Total bits = 16*(NUM_ZONES+1) = 5776 at the defaults.
  - Frame length from the flag edge is approximately bits*2*CLK_DIV + CLK_DIV + CS_GAP + 2 cycles.
- Counter widths:
  - Bit counter: 4 bits.
  - Word counter: 10 bits; it stops at NUM_ZONES and does not wrap.
  - Divider: $clog2(CLK_DIV+1) bits.

Optional Feature:
- Macro `SDBP_CRC_EN`.
- Defined: a CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is computed over every transmitted bit of the header and zone words. It is appended as one extra 16-bit word, MSB first, before GAP. The frame becomes 16*(NUM_ZONES+2) bits.
- Undefined: no CRC logic is built and the frame ends after the last zone word.

Decomposition:
- Shared package `sdbp_pkg` holds:
  - The FSM state enum: IDLE, START, SHIFT, CRC, GAP.
  - Default constants: NUM_ZONES, HDR_CMD, CRC_POLY, CRC_INIT.
- One natural sub-module, `sdbp_pingpong_ram`: two banks, a single write port, a single registered read port, and a bank-select input.
- The FSM, divider and shifter stay in the top module.

Test Plan:
- Write zones 0..359 with value = addr + 16'h0100, pulse `sdbp_flag`, CLK_DIV=2 → the receiver decodes 16'hA55A, then 16'h0100..16'h0267 in order. SCLK period is 4 clk. `frame_done` pulses once; `busy` is low afterwards.
- Rewrite all zones with 16'hFFFF during frame 1, then flag again after `frame_done` → frame 1 shows the old data untouched; frame 2 shows all 16'hFFFF.
- Raise a second `sdbp_flag` edge mid-frame → the frame is unaffected, no restart occurs, and `overrun`=1 and stays 1.
- Write with `wt_addr`=360 and 1023, value 16'hDEAD → no transmitted word equals 16'hDEAD unless it was written in range.
- Assert `rst_n` low at bit 100 of a frame → `cs_n`=1, `sclk`=0, `busy`=0 immediately. The next flag produces a full, correct frame starting with 16'hA55A.
- With `SDBP_CRC_EN` defined and all zones 0 → the last word equals the CRC-16-CCITT computed by the bench model over 16'hA55A followed by 360 zero words. Frame bit count = 5792.
